// File: rtl/jtag_bridge_pkg.sv
// Shared types and constants for the JTAG/UART bridge mux.
// Park levels are the idle levels a target sees when it is not routed.
package jtag_bridge_pkg;

    typedef enum logic {
        StRun    = 1'b0,
        StSwitch = 1'b1
    } state_e;

    localparam logic MODE_JTAG = 1'b1;
    localparam logic MODE_UART = 1'b0;

    localparam logic PARK_TCK  = 1'b1;
    localparam logic PARK_TMS  = 1'b1;
    localparam logic PARK_TDI  = 1'b1;
    localparam logic PARK_UART = 1'b1;
    localparam logic PARK_RSTN = 1'b1;
    localparam logic PARK_TDO  = 1'b1;

    localparam int unsigned LED_GREEN = 0;
    localparam int unsigned LED_BLUE  = 1;
    localparam int unsigned LED_RED   = 2;

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: each input pulse reloads a down-counter and
// the output stays high while the counter is nonzero.
module pulse_stretch #(
    parameter int unsigned STRETCH_CYC = 2400000
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic active
);

    localparam int unsigned CntW = $clog2(STRETCH_CYC + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(STRETCH_CYC);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pulse) begin
            cnt_q <= CntLoad;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign active = (cnt_q != '0);

endmodule

// File: rtl/jtag_uart_bridge_mux.sv
// Routes one host JTAG/UART port to one of NUM_TGT target headers. Mode and
// target changes are applied only once the host has been quiet for IDLE_CYC.
module jtag_uart_bridge_mux
    import jtag_bridge_pkg::*;
#(
    parameter int unsigned NUM_TGT      = 2,
    parameter int unsigned SEL_W        = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1,
    parameter int unsigned DEBOUNCE_CYC = 4096,
    parameter int unsigned IDLE_CYC     = 256,
    parameter int unsigned STRETCH_CYC  = 2400000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_tck,
    input  logic               host_tms,
    input  logic               host_tdi,
    output logic               host_tdo,
    input  logic               host_uart_tx,
    output logic               host_uart_rx,
    input  logic               mode_jumper,
    input  logic [SEL_W-1:0]   tgt_sel,
    output logic [NUM_TGT-1:0] tgt_tck,
    output logic [NUM_TGT-1:0] tgt_tms,
    output logic [NUM_TGT-1:0] tgt_tdi,
    input  logic [NUM_TGT-1:0] tgt_tdo,
    output logic [NUM_TGT-1:0] tgt_rstn,
    output logic [NUM_TGT-1:0] tgt_uart_rx,
    input  logic [NUM_TGT-1:0] tgt_uart_tx,
    output logic [SEL_W-1:0]   cur_tgt,
    output logic               cur_mode,
    output logic               switching,
    output logic               sel_err,
    output logic [2:0]         led_pwm
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned IdleW = $clog2(IDLE_CYC + 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYC - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_CYC - 1);

    // Synchronisers; bit 2 holds the previous synchronised value for edge detect.
    logic [2:0] tck_sync_q;
    logic [2:0] uart_sync_q;
    logic [1:0] jumper_sync_q;
    logic       tck_edge;
    logic       uart_edge;
    logic       host_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync_q    <= '1;
            uart_sync_q   <= '1;
            jumper_sync_q <= {2{MODE_JTAG}};
        end else begin
            tck_sync_q    <= {tck_sync_q[1:0], host_tck};
            uart_sync_q   <= {uart_sync_q[1:0], host_uart_tx};
            jumper_sync_q <= {jumper_sync_q[0], mode_jumper};
        end
    end

    assign tck_edge  = tck_sync_q[2] ^ tck_sync_q[1];
    assign uart_edge = uart_sync_q[2] ^ uart_sync_q[1];
    assign host_edge = tck_edge | uart_edge;

    // Jumper debounce: any return to the accepted value restarts the count.
    logic            mode_q;
    logic [DebW-1:0] deb_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_JTAG;
            deb_cnt_q <= '0;
        end else if (jumper_sync_q[1] == mode_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DebLast) begin
            mode_q    <= jumper_sync_q[1];
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    // Out-of-range selects fall back to the last valid request.
    logic             sel_valid;
    logic [SEL_W-1:0] req_tgt;
    logic [SEL_W-1:0] req_tgt_q;
    logic             sel_err_q;

    assign sel_valid = (32'(tgt_sel) < NUM_TGT);
    assign req_tgt   = sel_valid ? tgt_sel : req_tgt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_tgt_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            req_tgt_q <= req_tgt;
            if (!sel_valid) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    // Reconfiguration FSM.
    state_e           state_q;
    logic [SEL_W-1:0] cur_tgt_q;
    logic             cur_mode_q;
    logic             switching_q;
    logic [IdleW-1:0] idle_cnt_q;
    logic             req_differs;

    assign req_differs = (req_tgt != cur_tgt_q) || (mode_q != cur_mode_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            cur_tgt_q   <= '0;
            cur_mode_q  <= MODE_JTAG;
            switching_q <= 1'b0;
            idle_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (req_differs) begin
                        state_q     <= StSwitch;
                        switching_q <= 1'b1;
                        idle_cnt_q  <= '0;
                    end
                end
                StSwitch: begin
                    if (host_edge) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IdleLast) begin
                        cur_tgt_q   <= req_tgt;
                        cur_mode_q  <= mode_q;
                        state_q     <= StRun;
                        switching_q <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= StRun;
                    switching_q <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency data path; everything parks while a switch is pending.
    logic routed_run;
    assign routed_run = (state_q == StRun);

    always_comb begin
        tgt_tck      = {NUM_TGT{PARK_TCK}};
        tgt_tms      = {NUM_TGT{PARK_TMS}};
        tgt_tdi      = {NUM_TGT{PARK_TDI}};
        tgt_uart_rx  = {NUM_TGT{PARK_UART}};
        host_tdo     = PARK_TDO;
        host_uart_rx = PARK_UART;
        for (int i = 0; i < int'(NUM_TGT); i++) begin
            if (routed_run && (cur_tgt_q == SEL_W'(i))) begin
                if (cur_mode_q == MODE_JTAG) begin
                    tgt_tck[i] = host_tck;
                    tgt_tms[i] = host_tms;
                    tgt_tdi[i] = host_tdi;
                    host_tdo   = tgt_tdo[i];
                end else begin
                    tgt_uart_rx[i] = host_uart_tx;
                    host_uart_rx   = tgt_uart_tx[i];
                end
            end
        end
    end

    assign tgt_rstn = {NUM_TGT{PARK_RSTN}};

    // Activity LEDs.
    logic green_on;
    logic blue_on;

    pulse_stretch #(
        .STRETCH_CYC(STRETCH_CYC)
    ) u_green_stretch (
        .clk   (clk),
        .rst   (rst),
        .pulse (tck_edge & (cur_mode_q == MODE_JTAG)),
        .active(green_on)
    );

    pulse_stretch #(
        .STRETCH_CYC(STRETCH_CYC)
    ) u_blue_stretch (
        .clk   (clk),
        .rst   (rst),
        .pulse (uart_edge & (cur_mode_q == MODE_UART)),
        .active(blue_on)
    );

    always_comb begin
        led_pwm            = '0;
        led_pwm[LED_GREEN] = green_on;
        led_pwm[LED_BLUE]  = blue_on;
        led_pwm[LED_RED]   = switching_q | sel_err_q;
    end

    assign cur_tgt   = cur_tgt_q;
    assign cur_mode  = cur_mode_q;
    assign switching = switching_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_jtag_uart_bridge_mux.sv
// Directed bench for jtag_uart_bridge_mux: table-driven routing vectors plus
// hand-written sequences for switching, debounce, invalid select and reset.
module tb_jtag_uart_bridge_mux;

    localparam int unsigned NUM_TGT      = 3;
    localparam int unsigned SEL_W        = 2;
    localparam int unsigned DEBOUNCE_CYC = 64;
    localparam int unsigned IDLE_CYC     = 16;
    localparam int unsigned STRETCH_CYC  = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               host_tck, host_tms, host_tdi, host_tdo;
    logic               host_uart_tx, host_uart_rx;
    logic               mode_jumper;
    logic [SEL_W-1:0]   tgt_sel;
    logic [NUM_TGT-1:0] tgt_tck, tgt_tms, tgt_tdi, tgt_tdo, tgt_rstn;
    logic [NUM_TGT-1:0] tgt_uart_rx, tgt_uart_tx;
    logic [SEL_W-1:0]   cur_tgt;
    logic               cur_mode, switching, sel_err;
    logic [2:0]         led_pwm;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtag_uart_bridge_mux #(
        .NUM_TGT     (NUM_TGT),
        .SEL_W       (SEL_W),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .IDLE_CYC    (IDLE_CYC),
        .STRETCH_CYC (STRETCH_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_tck    (host_tck),
        .host_tms    (host_tms),
        .host_tdi    (host_tdi),
        .host_tdo    (host_tdo),
        .host_uart_tx(host_uart_tx),
        .host_uart_rx(host_uart_rx),
        .mode_jumper (mode_jumper),
        .tgt_sel     (tgt_sel),
        .tgt_tck     (tgt_tck),
        .tgt_tms     (tgt_tms),
        .tgt_tdi     (tgt_tdi),
        .tgt_tdo     (tgt_tdo),
        .tgt_rstn    (tgt_rstn),
        .tgt_uart_rx (tgt_uart_rx),
        .tgt_uart_tx (tgt_uart_tx),
        .cur_tgt     (cur_tgt),
        .cur_mode    (cur_mode),
        .switching   (switching),
        .sel_err     (sel_err),
        .led_pwm     (led_pwm)
    );

    typedef struct {
        int         ph;
        logic       tck, tms, tdi, utx;
        logic [2:0] tdo, utgt;
        logic [2:0] e_tck, e_tms, e_tdi, e_urx;
        logic       e_tdo, e_hurx;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_host();
        host_tck     = 1'b1;
        host_tms     = 1'b1;
        host_tdi     = 1'b1;
        host_uart_tx = 1'b1;
    endtask

    // Phase 0: JTAG/tgt0, phase 1: JTAG/tgt1, phase 2: UART/tgt0.
    task automatic apply_phase(input int p);
        foreach (vecs[k]) begin
            if (vecs[k].ph == p) begin
                @(negedge clk);
                host_tck     = vecs[k].tck;
                host_tms     = vecs[k].tms;
                host_tdi     = vecs[k].tdi;
                host_uart_tx = vecs[k].utx;
                tgt_tdo      = vecs[k].tdo;
                tgt_uart_tx  = vecs[k].utgt;
                #1;
                check($sformatf("vec%0d", k),
                      {18'd0, tgt_tck, tgt_tms, tgt_tdi, tgt_uart_rx, host_tdo, host_uart_rx},
                      {18'd0, vecs[k].e_tck, vecs[k].e_tms, vecs[k].e_tdi, vecs[k].e_urx,
                       vecs[k].e_tdo, vecs[k].e_hurx});
            end
        end
        @(negedge clk);
        idle_host();
        tick(5);
    endtask

    initial begin
        int cnt;

        vecs[0] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 3'b000,
                    3'b110, 3'b111, 3'b110, 3'b111, 1'b0, 1'b1};
        vecs[1] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000,
                    3'b111, 3'b110, 3'b111, 3'b111, 1'b1, 1'b1};
        vecs[2] = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 3'b111,
                    3'b110, 3'b110, 3'b110, 3'b111, 1'b1, 1'b1};
        vecs[3] = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b111,
                    3'b101, 3'b101, 3'b111, 3'b111, 1'b0, 1'b1};
        vecs[4] = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000,
                    3'b111, 3'b111, 3'b101, 3'b111, 1'b1, 1'b1};
        vecs[5] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b110,
                    3'b111, 3'b111, 3'b111, 3'b110, 1'b1, 1'b0};
        vecs[6] = '{2, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b001,
                    3'b111, 3'b111, 3'b111, 3'b111, 1'b1, 1'b1};

        // Reset defaults
        rst         = 1'b1;
        idle_host();
        mode_jumper = 1'b1;
        tgt_sel     = '0;
        tgt_tdo     = '0;
        tgt_uart_tx = '1;
        tick(2);
        host_tms = 1'b0;
        #1;
        check("rst_cur_tgt", cur_tgt, 0);
        check("rst_cur_mode", cur_mode, 1);
        check("rst_switching", switching, 0);
        check("rst_sel_err", sel_err, 0);
        check("rst_led", led_pwm, 3'b000);
        check("rst_tms_route", tgt_tms, 3'b110);
        check("rst_rstn", tgt_rstn, 3'b111);
        host_tms = 1'b1;
        rst      = 1'b0;
        tick(3);
        check("post_rst_switching", switching, 0);
        check("post_rst_led", led_pwm, 3'b000);

        apply_phase(0);

        // Target switch with a quiet host
        tgt_tdo = 3'b000;
        tgt_sel = 2'd1;
        tick(1);
        check("sw_enter", switching, 1);
        check("sw_park_tck", tgt_tck, 3'b111);
        check("sw_park_tdo", host_tdo, 1);
        check("sw_cur_hold", cur_tgt, 0);
        cnt = 0;
        while (switching && cnt < 200) begin
            cnt++;
            tick(1);
        end
        check("sw_len", cnt, IDLE_CYC);
        check("sw_cur_tgt", cur_tgt, 1);
        apply_phase(1);

        // Switch blocked while TCK toggles every 10 cycles
        tgt_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick(10);
            host_tck = ~host_tck;
        end
        check("blk_cur_hold", cur_tgt, 1);
        check("blk_switching", switching, 1);
        cnt = 0;
        while (cur_tgt != 2'd0 && cnt < 200) begin
            tick(1);
            cnt++;
        end
        check("blk_release", cnt, IDLE_CYC + 3);

        // Jumper bounce then steady UART
        for (int i = 0; i < 3; i++) begin
            mode_jumper = 1'b0;
            tick(50);
            mode_jumper = 1'b1;
            tick(50);
        end
        check("bnc_mode_hold", cur_mode, 1);
        check("bnc_no_switch", switching, 0);
        mode_jumper = 1'b0;
        cnt = 0;
        while (cur_mode != 1'b0 && cnt < 1000) begin
            tick(1);
            cnt++;
        end
        check("bnc_latency", cnt, DEBOUNCE_CYC + IDLE_CYC + 3);
        apply_phase(2);
        check("led_blue", led_pwm, 3'b010);

        // Invalid select
        tgt_uart_tx = 3'b110;
        tgt_sel     = 2'd3;
        tick(2);
        check("inv_sel_err", sel_err, 1);
        check("inv_red", led_pwm[2], 1);
        check("inv_no_switch", switching, 0);
        check("inv_cur_tgt", cur_tgt, 0);
        check("inv_route", host_uart_rx, 0);
        tgt_sel = 2'd2;
        tick(1);
        check("inv_next_switch", switching, 1);
        cnt = 0;
        while (switching && cnt < 200) begin
            cnt++;
            tick(1);
        end
        check("inv_next_len", cnt, IDLE_CYC);
        check("inv_next_tgt", cur_tgt, 2);
        check("inv_sticky", sel_err, 1);

        // Back to JTAG, then single TCK edge stretches green
        mode_jumper = 1'b1;
        cnt = 0;
        while ((cur_mode != 1'b1 || switching) && cnt < 1000) begin
            tick(1);
            cnt++;
        end
        check("jtag_back", cur_mode, 1);
        tick(STRETCH_CYC + 4);
        check("grn_idle", led_pwm[0], 0);
        host_tck = 1'b0;
        cnt = 0;
        while (!led_pwm[0] && cnt < 10) begin
            tick(1);
            cnt++;
        end
        cnt = 0;
        while (led_pwm[0] && cnt < 100) begin
            cnt++;
            tick(1);
        end
        check("grn_len", cnt, STRETCH_CYC);

        // Reset during SWITCH
        tgt_sel = 2'd1;
        tick(3);
        check("rsw_in_switch", switching, 1);
        rst     = 1'b1;
        tgt_sel = 2'd0;
        tick(1);
        check("rsw_switching", switching, 0);
        check("rsw_cur_tgt", cur_tgt, 0);
        check("rsw_cur_mode", cur_mode, 1);
        check("rsw_sel_err", sel_err, 0);
        check("rsw_led", led_pwm, 3'b000);
        rst = 1'b0;
        tick(3);
        check("rsw_no_pending", switching, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
